// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single RAM port: data has priority over fetch,
// a saturating starvation count forces fetch through, and a grant timeout forces an error completion.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TOUT_MAX   = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_e;

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [7:0]  tcnt_q, tcnt_d;
   logic        err_q, err_d;

   logic        dreq, ram_acc, finish;
   logic [31:0] word;

   assign dreq    = dREN | dWEN;
   assign ram_acc = (ramstate == RAM_ACCESS);
   // ACCESS outranks a coincident timeout: the RAM did deliver, so no error is raised.
   assign finish  = ram_acc || (ramstate == RAM_ERROR) || (tcnt_q == TOUT_MAX);
   assign word    = ram_acc ? ramload : ERR_WORD;
   assign err     = err_q;

   always_comb begin
      // NOTE: every output and next-state value gets a default first so no path infers a latch.
      state_d  = state_q;
      starve_d = starve_q;
      tcnt_d   = tcnt_q;
      err_d    = err_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = iREN;
      dwait    = dreq;
      iload    = '0;
      dload    = '0;
      unique case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (iREN && (!dreq || starve_q == STARVE_MAX)) state_d = IGNT;
            else if (dreq)                                 state_d = DGNT;
         end
         IGNT: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (finish) begin
                  iwait    = 1'b0;
                  iload    = word;
                  err_d    = err_q | !ram_acc;
                  starve_d = '0;
                  state_d  = IDLE;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         DGNT: begin
            if (!dreq) begin
               state_d = IDLE;
            end else begin
               ramWEN   = dWEN;
               ramREN   = dREN & !dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (finish) begin
                  dwait   = 1'b0;
                  dload   = word;
                  err_d   = err_q | !ram_acc;
                  state_d = IDLE;
                  if (!iREN)                      starve_d = '0;
                  else if (starve_q != STARVE_MAX) starve_d = starve_q + 4'd1;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         starve_q <= '0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         tcnt_q   <= tcnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level ownership model.
module tb_mem_arbiter;

   localparam int          STARVE_LIMIT = 4;
   localparam int          TIMEOUT      = 8;
   localparam logic [31:0] ERR_WORD     = 32'hBAD1BAD1;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: who owns the RAM (0 none, 1 fetch, 2 data), how long the grant has lasted,
   // how many data completions in a row passed a waiting fetch, and the sticky error.
   int owner, grant_age, streak;
   bit m_err;
   bit e_iwait, e_dwait, e_ramREN, e_ramWEN, done_i, done_d;
   logic [31:0] e_iload, e_dload, e_ramaddr, e_ramstore;
   bit o_iwait, o_dwait, o_ramREN, o_ramWEN, o_err;
   logic [31:0] o_iload, o_dload, o_ramaddr, o_ramstore;

   task automatic model_reset();
      owner = 0; grant_age = 0; streak = 0; m_err = 0;
   endtask

   task automatic model_eval();
      bit dreq, fin;
      logic [31:0] word;
      dreq = dREN | dWEN;
      fin  = (ramstate == 2'd2) || (ramstate == 2'd3) || (grant_age == TIMEOUT);
      word = (ramstate == 2'd2) ? ramload : ERR_WORD;
      e_iwait = iREN; e_dwait = dreq; e_ramREN = 0; e_ramWEN = 0;
      e_iload = 0; e_dload = 0; e_ramaddr = 0; e_ramstore = 0;
      done_i = 0; done_d = 0;
      if (owner == 1 && iREN) begin
         e_ramREN = 1; e_ramaddr = iaddr;
         if (fin) begin done_i = 1; e_iwait = 0; e_iload = word; end
      end else if (owner == 2 && dreq) begin
         e_ramWEN = dWEN; e_ramREN = dREN && !dWEN; e_ramaddr = daddr; e_ramstore = dstore;
         if (fin) begin done_d = 1; e_dwait = 0; e_dload = word; end
      end
   endtask

   task automatic model_next();
      bit dreq;
      dreq = dREN | dWEN;
      if (done_i || done_d) begin
         if (ramstate != 2'd2) m_err = 1;
         if (done_d && iREN) streak = (streak < STARVE_LIMIT) ? streak + 1 : STARVE_LIMIT;
         else streak = 0;
      end
      if (owner == 0) begin
         grant_age = 0;
         if (iREN && (!dreq || streak == STARVE_LIMIT)) owner = 1;
         else if (dreq) owner = 2;
      end else if (done_i || done_d || (owner == 1 && !iREN) || (owner == 2 && !dreq)) begin
         owner = 0;
      end else begin
         grant_age++;
      end
   endtask

   task automatic compare_all();
      model_eval();
      o_iwait = iwait; o_dwait = dwait; o_ramREN = ramREN; o_ramWEN = ramWEN; o_err = err;
      o_iload = iload; o_dload = dload; o_ramaddr = ramaddr; o_ramstore = ramstore;
      check("iwait",    32'(iwait),  32'(e_iwait));
      check("dwait",    32'(dwait),  32'(e_dwait));
      check("iload",    iload,       e_iload);
      check("dload",    dload,       e_dload);
      check("ramREN",   32'(ramREN), 32'(e_ramREN));
      check("ramWEN",   32'(ramWEN), 32'(e_ramWEN));
      check("ramaddr",  ramaddr,     e_ramaddr);
      check("ramstore", ramstore,    e_ramstore);
      check("err",      32'(err),    32'(m_err));
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic cycle();
      #2;
      compare_all();
      if (nRST) model_next();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic quiet();
      iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
      ramstate = 2'd0; ramload = 0;
   endtask

   int lows, nd, ni, gcyc;
   bit first_is_data;

   initial begin
      quiet();
      nRST = 0;
      model_reset();
      @(negedge CLK);
      cycle();
      check("reset_ramREN", 32'(o_ramREN), 32'd0);
      check("reset_err", 32'(o_err), 32'd0);
      nRST = 1;
      cycle();

      // Single fetch with two BUSY cycles before ACCESS.
      iREN = 1; iaddr = 32'h40;
      cycle();
      check("fetch_idle_ramREN", 32'(o_ramREN), 32'd0);
      lows = 0;
      ramstate = 2'd1;
      cycle(); if (!o_iwait) lows++;
      check("fetch_ramaddr", o_ramaddr, 32'h40);
      cycle(); if (!o_iwait) lows++;
      ramstate = 2'd2; ramload = 32'h8C010004;
      cycle(); if (!o_iwait) lows++;
      check("fetch_iload", o_iload, 32'h8C010004);
      check("fetch_done_count", 32'(lows), 32'd1);
      iREN = 0; ramstate = 2'd0;
      cycle();
      check("fetch_after_idle", 32'(o_ramREN), 32'd0);

      // Contention: data write wins, fetch follows after one idle cycle.
      iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      cycle();
      ramstate = 2'd2; ramload = 32'h11112222;
      cycle();
      check("cont_ramWEN", 32'(o_ramWEN), 32'd1);
      check("cont_ramaddr", o_ramaddr, 32'h100);
      check("cont_ramstore", o_ramstore, 32'hDEADBEEF);
      check("cont_iwait_held", 32'(o_iwait), 32'd1);
      dWEN = 0;
      cycle();
      check("cont_turnaround", 32'(o_ramREN), 32'd0);
      cycle();
      check("cont_fetch_addr", o_ramaddr, 32'h80);
      check("cont_fetch_iload", o_iload, 32'h11112222);
      iREN = 0;
      cycle();

      // Starvation: both requests held, RAM always ready.
      iREN = 1; dREN = 1; daddr = 32'h200; ramstate = 2'd2; ramload = 32'h5;
      nd = 0; ni = 0;
      for (int k = 0; k < 30 && ni == 0; k++) begin
         cycle();
         if (!o_iwait) ni++;
         else if (!o_dwait) nd++;
      end
      check("starve_data_count", 32'(nd), 32'(STARVE_LIMIT));
      check("starve_fetch_served", 32'(ni), 32'd1);
      first_is_data = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (!o_dwait || !o_iwait) begin first_is_data = !o_dwait; break; end
      end
      check("starve_cleared", 32'(first_is_data), 32'd1);
      quiet();
      cycle();

      // ERROR completion on a data read, then sticky err across a good fetch.
      dREN = 1; daddr = 32'h300; ramstate = 2'd3;
      cycle();
      cycle();
      check("error_dload", o_dload, ERR_WORD);
      check("error_dwait", 32'(o_dwait), 32'd0);
      dREN = 0; iREN = 1; ramstate = 2'd2;
      cycle();
      check("error_flag", 32'(o_err), 32'd1);
      cycle();
      iREN = 0;
      cycle();
      check("error_sticky", 32'(o_err), 32'd1);

      // Timeout: RAM stuck BUSY.
      dREN = 1; ramstate = 2'd1;
      cycle();
      gcyc = 0;
      for (int k = 0; k < 30; k++) begin
         cycle();
         if (o_ramREN) gcyc++;
         if (!o_dwait) break;
      end
      check("timeout_cycles", 32'(gcyc), 32'(TIMEOUT + 1));
      check("timeout_dload", o_dload, ERR_WORD);
      dREN = 0;
      cycle();

      // Withdrawal mid-grant.
      dREN = 1; daddr = 32'h400; ramstate = 2'd1;
      cycle();
      cycle();
      check("wd_granted", 32'(o_ramREN), 32'd1);
      dREN = 0;
      cycle();
      check("wd_strobe_drop", 32'(o_ramREN), 32'd0);
      dREN = 1;
      cycle();
      check("wd_back_to_idle", 32'(o_ramREN), 32'd0);
      dREN = 0;
      cycle();

      // Reset asserted during a fetch grant.
      iREN = 1; iaddr = 32'h500; ramstate = 2'd1;
      cycle();
      cycle();
      #2 nRST = 0;
      model_reset();
      #1;
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      check("rst_iwait", 32'(iwait), 32'd1);
      check("rst_err", 32'(err), 32'd0);
      @(negedge CLK);
      cycle();
      nRST = 1; ramstate = 2'd2; ramload = 32'hCAFE0001;
      cycle();
      cycle();
      check("rst_first_fetch", o_iload, 32'hCAFE0001);
      quiet();
      cycle();

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         if (!iREN || !o_iwait || $urandom_range(0, 31) == 0) begin
            iREN  = ($urandom_range(0, 2) != 0);
            iaddr = $urandom;
         end
         if (!(dREN || dWEN) || !o_dwait || $urandom_range(0, 31) == 0) begin
            case ($urandom_range(0, 3))
               0: begin dREN = 0; dWEN = 0; end
               1: begin dREN = 1; dWEN = 0; end
               2: begin dREN = 0; dWEN = 1; end
               default: begin dREN = 1; dWEN = 1; end
            endcase
            daddr = $urandom; dstore = $urandom;
         end
         case ($urandom_range(0, 9))
            0:       ramstate = 2'd0;
            1, 2, 3, 4: ramstate = 2'd1;
            9:       ramstate = 2'd3;
            default: ramstate = 2'd2;
         endcase
         ramload = $urandom;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
